// File: rtl/pwm_deadtime_if.sv
// -----------------------------------------------------------------------------
// pwm_deadtime_if
// Purpose : Groups the data/control signals of the pwm_deadtime stage.
//           The master side drives the PWM input and controls and observes
//           the gate-drive outputs. The slave side is the dead-time block.
// Signals :
//   pwm_in        single-ended PWM from the upstream pwm_out block
//   dt_cycles     dead interval length in clk cycles (DT_WIDTH bits)
//   enable        1 = drive outputs, 0 = both outputs off
//   fault_in      external level-sensitive fault
//   fault_clr     clears the latched fault
//   pwm_hi        high-side gate drive
//   pwm_lo        low-side gate drive
//   fault_latched 1 while the block sits in its fault state
//   sw_count      completed switching cycles (only with PWM_DEADTIME_SWCOUNT_EN)
// Config  : `define PWM_DEADTIME_SWCOUNT_EN adds sw_count.
// -----------------------------------------------------------------------------
interface pwm_deadtime_if #(
  parameter int DT_WIDTH = 8
) ();
  logic                pwm_in;
  logic [DT_WIDTH-1:0] dt_cycles;
  logic                enable;
  logic                fault_in;
  logic                fault_clr;
  logic                pwm_hi;
  logic                pwm_lo;
  logic                fault_latched;
`ifdef PWM_DEADTIME_SWCOUNT_EN
  logic [15:0]         sw_count;

  modport master (
    output pwm_in, dt_cycles, enable, fault_in, fault_clr,
    input  pwm_hi, pwm_lo, fault_latched, sw_count
  );
  modport slave (
    input  pwm_in, dt_cycles, enable, fault_in, fault_clr,
    output pwm_hi, pwm_lo, fault_latched, sw_count
  );
`else
  modport master (
    output pwm_in, dt_cycles, enable, fault_in, fault_clr,
    input  pwm_hi, pwm_lo, fault_latched
  );
  modport slave (
    input  pwm_in, dt_cycles, enable, fault_in, fault_clr,
    output pwm_hi, pwm_lo, fault_latched
  );
`endif
endinterface

// File: rtl/pwm_deadtime.sv
// -----------------------------------------------------------------------------
// pwm_deadtime
// Purpose : Turns a single-ended PWM into a complementary high/low gate-drive
//           pair with a programmable dead interval at every commutation,
//           enable gating and a latched fault shutdown.
// Ports   :
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - pwm_deadtime_if.slave (pwm_in, dt_cycles, enable, fault_in,
//          fault_clr in; pwm_hi, pwm_lo, fault_latched [, sw_count] out)
// Config  : `define PWM_DEADTIME_SWCOUNT_EN adds the saturating 16-bit
//           sw_count of completed HI_ON -> DT_TO_LO commutations.
// -----------------------------------------------------------------------------
module pwm_deadtime #(
  parameter int DT_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  pwm_deadtime_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HI_ON    = 3'd1,
    S_LO_ON    = 3'd2,
    S_DT_TO_HI = 3'd3,
    S_DT_TO_LO = 3'd4,
    S_FAULT    = 3'd5
  } state_e;

  localparam logic [DT_WIDTH-1:0] CNT_ZERO = DT_WIDTH'(1'b0);
  localparam logic [DT_WIDTH-1:0] CNT_ONE  = DT_WIDTH'(1'b1);

  state_e              state_q, state_d;
  logic                pwm_q, pwm_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                hi_q, hi_d;
  logic                lo_q, lo_d;
  logic                flt_q, flt_d;
  logic [DT_WIDTH-1:0] dt_in_s;
  logic [DT_WIDTH-1:0] dt_load_s;

  function automatic logic is_dead(input state_e s);
    return (s == S_DT_TO_HI) || (s == S_DT_TO_LO);
  endfunction

  assign dt_in_s   = bus.dt_cycles;
  // Zero dead time is never allowed: a request of 0 becomes 1 cycle.
  assign dt_load_s = (dt_in_s == CNT_ZERO) ? CNT_ONE : dt_in_s;
  assign pwm_d     = bus.pwm_in;

  // State register: FSM state, input sync flop, dead counter and output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pwm_q   <= 1'b0;
      cnt_q   <= CNT_ZERO;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pwm_q   <= pwm_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      flt_q   <= flt_d;
    end
  end

  // Next-state logic: fault beats enable beats normal commutation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.fault_in) begin
      state_d = S_FAULT;
    end else if (state_q == S_FAULT) begin
      // fault_in is already known low here, so fault_clr alone releases.
      if (bus.fault_clr) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_FAULT;
      end
    end else if (!bus.enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = pwm_q ? S_DT_TO_HI : S_DT_TO_LO;
        S_LO_ON: state_d = pwm_q ? S_DT_TO_HI : S_LO_ON;
        S_HI_ON: state_d = pwm_q ? S_HI_ON : S_DT_TO_LO;
        S_DT_TO_HI, S_DT_TO_LO: begin
          // Exit direction follows pwm_q at the end of the interval,
          // not the direction that started it.
          if (cnt_q <= CNT_ONE) begin
            state_d = pwm_q ? S_HI_ON : S_LO_ON;
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Counter holds the remaining dead cycles including the current one.
    if (is_dead(state_d) && (state_d != state_q)) begin
      cnt_d = dt_load_s;
    end else if (is_dead(state_q) && (cnt_q > CNT_ONE)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output decode from the next state so the registered drives line up
  // with the state they belong to; a single-state decode makes hi&lo
  // mutually exclusive by construction.
  always_comb begin
    hi_d  = 1'b0;
    lo_d  = 1'b0;
    flt_d = 1'b0;
    case (state_d)
      S_HI_ON: hi_d  = 1'b1;
      S_LO_ON: lo_d  = 1'b1;
      S_FAULT: flt_d = 1'b1;
      default: begin
        hi_d  = 1'b0;
        lo_d  = 1'b0;
        flt_d = 1'b0;
      end
    endcase
  end

  assign bus.pwm_hi        = hi_q;
  assign bus.pwm_lo        = lo_q;
  assign bus.fault_latched = flt_q;

`ifdef PWM_DEADTIME_SWCOUNT_EN
  logic [15:0] sw_q, sw_d;

  // Switching-cycle counter: one count per HI_ON -> DT_TO_LO, saturating.
  always_comb begin
    if ((state_q == S_HI_ON) && (state_d == S_DT_TO_LO) && (sw_q != 16'hFFFF)) begin
      sw_d = sw_q + 16'd1;
    end else begin
      sw_d = sw_q;
    end
  end

  // Switching-cycle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q <= 16'd0;
    end else begin
      sw_q <= sw_d;
    end
  end

  assign bus.sw_count = sw_q;
`endif

endmodule

// File: tb/tb_pwm_deadtime.sv
// -----------------------------------------------------------------------------
// tb_pwm_deadtime
// Directed stimulus pushes time-stamped expected outputs into a scoreboard
// queue; a monitor on the falling clock edge pops and compares entries whose
// cycle has arrived, and checks hi&lo exclusivity every cycle.
// Define PWM_DEADTIME_SWCOUNT_EN to also exercise sw_count.
// -----------------------------------------------------------------------------
module tb_pwm_deadtime;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  typedef struct {
    int          cyc;
    logic        chk_out;
    logic        hi;
    logic        lo;
    logic        flt;
    logic        chk_sw;
    logic [15:0] sw;
    string       nm;
  } exp_t;

  exp_t sb[$];

  pwm_deadtime_if #(.DT_WIDTH(8)) bus ();

  pwm_deadtime #(.DT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: exclusivity every cycle, then any scoreboard entries due now.
  always @(negedge clk) begin
    exp_t e;
    n_checks++;
    if (bus.pwm_hi === 1'b1 && bus.pwm_lo === 1'b1) begin
      n_errors++;
      $display("FAIL overlap cyc=%0d: hi=1 lo=1, required not both 1", cyc);
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.cyc < cyc) begin
        n_errors++;
        $display("FAIL %s: entry for cyc %0d missed at cyc %0d", e.nm, e.cyc, cyc);
      end else begin
        if (e.chk_out && ({bus.pwm_hi, bus.pwm_lo, bus.fault_latched} !== {e.hi, e.lo, e.flt})) begin
          n_errors++;
          $display("FAIL %s cyc=%0d: hi/lo/flt=%b%b%b, required %b%b%b", e.nm, cyc,
                   bus.pwm_hi, bus.pwm_lo, bus.fault_latched, e.hi, e.lo, e.flt);
        end
`ifdef PWM_DEADTIME_SWCOUNT_EN
        if (e.chk_sw && (bus.sw_count !== e.sw)) begin
          n_errors++;
          $display("FAIL %s cyc=%0d: sw_count=%0d, required %0d", e.nm, cyc, bus.sw_count, e.sw);
        end
`endif
      end
    end
  end

  task automatic push(input exp_t e);
    int i;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > e.cyc) i--;
    sb.insert(i, e);
  endtask

  task automatic expect_at(input int off, input logic h, input logic l, input logic f, input string nm);
    exp_t e;
    e.cyc = cyc + off; e.chk_out = 1'b1; e.hi = h; e.lo = l; e.flt = f;
    e.chk_sw = 1'b0; e.sw = 16'd0; e.nm = nm;
    push(e);
  endtask

  task automatic expect_sw(input int off, input logic [15:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + off; e.chk_out = 1'b0; e.hi = 1'b0; e.lo = 1'b0; e.flt = 1'b0;
    e.chk_sw = 1'b1; e.sw = v; e.nm = nm;
    push(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new pwm_in level from a steady ON state of the opposite level:
  // old drive one edge later, both off from edge +2 for nd cycles, then new.
  task automatic commutate(input logic lvl, input int nd, input string nm);
    bus.pwm_in = lvl;
    expect_at(1, ~lvl, lvl, 1'b0, {nm, "_pre"});
    expect_at(2, 1'b0, 1'b0, 1'b0, {nm, "_dt_first"});
    expect_at(1 + nd, 1'b0, 1'b0, 1'b0, {nm, "_dt_last"});
    expect_at(2 + nd, lvl, ~lvl, 1'b0, {nm, "_on"});
  endtask

  initial begin
    rst           = 1'b1;
    bus.pwm_in    = 1'b0;
    bus.dt_cycles = 8'd5;
    bus.enable    = 1'b0;
    bus.fault_in  = 1'b0;
    bus.fault_clr = 1'b0;

    // 1: reset, then first conduction after a 5-cycle dead interval
    tick(1);
    expect_at(0, 1'b0, 1'b0, 1'b0, "reset_vals");
    tick(2);
    rst        = 1'b0;
    bus.enable = 1'b1;
    expect_at(1, 1'b0, 1'b0, 1'b0, "t1_dt_first");
    expect_at(3, 1'b0, 1'b0, 1'b0, "t1_dt_mid");
    expect_at(5, 1'b0, 1'b0, 1'b0, "t1_dt_last");
    expect_at(6, 1'b0, 1'b1, 1'b0, "t1_lo_on");
    tick(12);

    // 2: 256-cycle square wave, dt=10
    bus.dt_cycles = 8'd10;
    for (int p = 0; p < 2; p++) begin
      commutate(1'b1, 10, "t2_rise");
      tick(128);
      commutate(1'b0, 10, "t2_fall");
      tick(128);
    end

    // 3: dt=0 acts as 1; dt=255 with a glitch and a mid-interval dt change
    bus.dt_cycles = 8'd0;
    commutate(1'b1, 1, "t3_dt0");
    tick(20);
    bus.dt_cycles = 8'd255;
    commutate(1'b0, 255, "t3_dt255");
    expect_at(100, 1'b0, 1'b0, 1'b0, "t3_dt255_mid");
    tick(50);
    bus.pwm_in    = 1'b1;
    bus.dt_cycles = 8'd3;
    tick(3);
    bus.pwm_in = 1'b0;
    tick(215);

    // 4: fault while HI_ON, ignored clear, then release and resume
    commutate(1'b1, 3, "t4_setup");
    tick(10);
    bus.fault_in = 1'b1;
    expect_at(1, 1'b0, 1'b0, 1'b1, "t4_fault_enter");
    expect_at(4, 1'b0, 1'b0, 1'b1, "t4_fault_held");
    tick(1);
    bus.fault_in = 1'b0;
    tick(3);
    bus.fault_in  = 1'b1;
    bus.fault_clr = 1'b1;
    expect_at(1, 1'b0, 1'b0, 1'b1, "t4_clr_ignored");
    tick(1);
    bus.fault_in = 1'b0;
    expect_at(1, 1'b0, 1'b0, 1'b0, "t4_idle");
    expect_at(2, 1'b0, 1'b0, 1'b0, "t4_dt_first");
    expect_at(4, 1'b0, 1'b0, 1'b0, "t4_dt_last");
    expect_at(5, 1'b1, 1'b0, 1'b0, "t4_resume_hi");
    tick(1);
    bus.fault_clr = 1'b0;
    tick(8);

    // 5: enable drop mid HI_ON, re-enable, reset mid DT_TO_LO
    expect_at(0, 1'b1, 1'b0, 1'b0, "t5_hi_before");
    bus.enable = 1'b0;
    expect_at(1, 1'b0, 1'b0, 1'b0, "t5_disabled");
    expect_at(3, 1'b0, 1'b0, 1'b0, "t5_disabled_held");
    tick(3);
    bus.enable = 1'b1;
    expect_at(3, 1'b0, 1'b0, 1'b0, "t5_reen_dt_last");
    expect_at(4, 1'b1, 1'b0, 1'b0, "t5_reen_hi");
    tick(8);
    bus.pwm_in = 1'b0;
    expect_at(1, 1'b1, 1'b0, 1'b0, "t5_fall_pre");
    expect_at(2, 1'b0, 1'b0, 1'b0, "t5_fall_dt");
    tick(3);
    rst = 1'b1;
    expect_at(1, 1'b0, 1'b0, 1'b0, "t5_rst_dt");
    tick(1);
    bus.fault_in = 1'b1;
    expect_at(2, 1'b0, 1'b0, 1'b0, "t5_rst_over_fault");
    tick(3);
    rst          = 1'b0;
    bus.fault_in = 1'b0;
    expect_at(4, 1'b0, 1'b1, 1'b0, "t5_after_rst_lo");
    tick(10);

`ifdef PWM_DEADTIME_SWCOUNT_EN
    // 6: 20 full periods counted, frozen in fault, cleared by reset
    bus.dt_cycles = 8'd2;
    expect_sw(0, 16'd0, "t6_sw_start");
    for (int p = 0; p < 20; p++) begin
      commutate(1'b1, 2, "t6_rise");
      tick(16);
      commutate(1'b0, 2, "t6_fall");
      if (p == 0) expect_sw(3, 16'd1, "t6_sw_first");
      tick(16);
    end
    expect_sw(0, 16'd20, "t6_sw_20");
    bus.fault_in = 1'b1;
    expect_at(1, 1'b0, 1'b0, 1'b1, "t6_fault");
    tick(1);
    bus.fault_in = 1'b0;
    bus.pwm_in   = 1'b1;
    tick(3);
    bus.pwm_in = 1'b0;
    tick(3);
    expect_sw(0, 16'd20, "t6_sw_frozen");
    rst = 1'b1;
    expect_sw(1, 16'd0, "t6_sw_rst");
    tick(2);
    rst = 1'b0;
    tick(5);
`endif

    tick(5);
    if (sb.size() != 0) begin
      n_errors += sb.size();
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
